tribus_arbiter: RTL

- Sequences a shared tri-state bus node so that at most one driver is enabled at any time.
- NREQ requesters compete for the bus through a req/gnt handshake. The block drives the one-hot output-enable vector and a turnaround gap between owners.
- It also provides the equivalent selector-mux view of the bus (bus_data/bus_valid) for on-chip consumers that cannot use a resolved tri-state net.
- Sits between the requesting agents and the bidir pad/bus driver logic.

---
 rtl/tribus_arbiter_if.sv | 30 +++
 rtl/tribus_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/tribus_arbiter_if.sv
// Bundles the requester-side and bus-side signals of the tri-state bus arbiter.
// Latency: none (wires only).
// Backpressure: none; req is a level-sensitive request and gnt is the only flow control.
interface tribus_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] data_in;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    oe;
    logic [OW-1:0]      owner;
    logic [DW-1:0]      bus_data;
    logic               bus_valid;
    logic               busy;

    // Requesting agents: drive requests and data, observe grant/bus.
    modport master (
        output req, data_in,
        input  gnt, oe, owner, bus_data, bus_valid, busy
    );

    // Arbiter side.
    modport slave (
        input  req, data_in,
        output gnt, oe, owner, bus_data, bus_valid, busy
    );
endinterface

// File: rtl/tribus_arbiter.sv
// Round-robin owner sequencing for a shared tri-state bus, with a turnaround gap between owners.
// Latency: req to registered gnt/oe is 1 cycle; bus_data/bus_valid follow gnt with no extra delay.
// Backpressure: requesters wait at req until granted; an owner is held at most MAX_HOLD cycles.
module tribus_arbiter #(
    parameter int NREQ       = 4,
    parameter int DW         = 8,
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic            clk,
    input  logic            rst,
    tribus_arbiter_if.slave bus
);
    localparam int OW = $clog2(NREQ);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int TW = 2;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_ptr, rr_d;
    logic [HW-1:0]   hold_cnt, hold_d;
    logic [TW-1:0]   turn_cnt, turn_d;

    logic            win_vld;
    logic [OW-1:0]   win_idx;
    logic [OW-1:0]   cand;
    logic            rel;

    // Round-robin pick: first set req bit scanning upward from rr_ptr, wrapping.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = OW'((int'(rr_ptr) + k) % NREQ);
            if (!win_vld && bus.req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Owner gives the bus up when it drops its request or uses its full hold budget.
    assign rel = !bus.req[owner_q] || (hold_cnt == HOLD_LAST);

    // State and grant registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            state    <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            rr_ptr   <= rr_d;
            hold_cnt <= hold_d;
            turn_cnt <= turn_d;
        end
    end

    // Next-state: arbitrate only in IDLE, so every owner change passes through at least one dead cycle.
    always_comb begin
        state_d = state;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        rr_d    = rr_ptr;
        hold_d  = hold_cnt;
        turn_d  = turn_cnt;
        case (state)
            S_IDLE: begin
                if (win_vld) begin
                    state_d = S_GRANT;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                    owner_d = win_idx;
                    hold_d  = '0;
                end
            end
            S_GRANT: begin
                if (rel) begin
                    gnt_d = '0;
                    rr_d  = OW'((int'(owner_q) + 1) % NREQ);
                    if (TURNAROUND > 0) begin
                        state_d = S_TURN;
                        turn_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_d = hold_cnt + 1'b1;
                end
            end
            S_TURN: begin
                if (turn_cnt == TURN_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    turn_d = turn_cnt + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Outputs: oe mirrors the registered grant; the mux view selects the owner's slice.
    always_comb begin
        bus.gnt       = gnt_q;
        bus.oe        = gnt_q;
        bus.owner     = owner_q;
        bus.busy      = (state != S_IDLE);
        bus.bus_valid = |gnt_q;
        bus.bus_data  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if ((|gnt_q) && (owner_q == OW'(k))) begin
                bus.bus_data = bus.data_in[k*DW +: DW];
            end
        end
    end
endmodule
